// File: rtl/ghash_pkg.sv
// Shared definitions for the GHASH accumulator: FSM states, the GF(2^128)
// reduction polynomial, and the bit-order and reduction helper functions.
package ghash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    MUL,
    RED,
    OUT
  } ghash_state_e;

  // Low-order terms of P(x) = x^128 + x^7 + x^2 + x + 1.
  localparam logic [127:0] GF128_POLY_LO = 128'h87;

  function automatic logic [127:0] bit_reverse128(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) begin
      r[i] = v[127-i];
    end
    return r;
  endfunction

  // x^128 == x^7 + x^2 + x + 1: fold the upper half down once into 135 bits,
  // then fold the 7 overflow bits a second time.
  function automatic logic [127:0] gf128_reduce(input logic [255:0] p);
    logic [127:0] t;
    logic [134:0] r;
    logic [6:0]   u;
    logic [127:0] res;
    t = p[255:128];
    r = {7'd0, p[127:0]};
    for (int i = 0; i < 8; i++) begin
      if (GF128_POLY_LO[i]) r = r ^ ({7'd0, t} << i);
    end
    u   = r[134:128];
    res = r[127:0];
    for (int i = 0; i < 8; i++) begin
      if (GF128_POLY_LO[i]) res = res ^ ({121'd0, u} << i);
    end
    return res;
  endfunction

endpackage

// File: rtl/carry_less_mul.sv
// Combinational carry-less (GF(2) polynomial) multiplier.
module carry_less_mul #(
  parameter int WIDTH_IN  = 128,
  parameter int WIDTH_OUT = 256
) (
  input  logic [WIDTH_IN-1:0]  a_i,
  input  logic [WIDTH_IN-1:0]  b_i,
  output logic [WIDTH_OUT-1:0] p_o
);

  logic [WIDTH_OUT-1:0] a_ext;

  assign a_ext = {{(WIDTH_OUT-WIDTH_IN){1'b0}}, a_i};

  always_comb begin
    p_o = '0;
    for (int i = 0; i < WIDTH_IN; i++) begin
      if (b_i[i]) p_o = p_o ^ (a_ext << i);
    end
  end

endmodule

// File: rtl/ghash_accumulator.sv
// GHASH accumulator: Y_i = (Y_{i-1} ^ X_i) * H over GF(2^128), one block per
// three cycles (accept, multiply into prod_q, reduce into Y).
module ghash_accumulator
  import ghash_pkg::*;
#(
  parameter int WIDTH   = 128,
  parameter int CNT_W   = 32,
  parameter bit REFLECT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] h_in,
  input  logic             h_load,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  if (WIDTH != 128) begin : g_width_check
    $error("ghash_accumulator supports only WIDTH=128");
  end

  ghash_state_e         state_q, state_d;
  logic [WIDTH-1:0]     h_q, y_q, opx_q;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 last_q;
  logic [WIDTH-1:0]     x_ord, h_ord;

  // Internal arithmetic is plain polynomial order; GCM order is mapped at the ports.
  assign x_ord = REFLECT ? bit_reverse128(in_data) : in_data;
  assign h_ord = REFLECT ? bit_reverse128(h_in)    : h_in;

  carry_less_mul #(
    .WIDTH_IN  (WIDTH),
    .WIDTH_OUT (2*WIDTH)
  ) u_clmul (
    .a_i (opx_q),
    .b_i (h_q),
    .p_o (prod_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:   if (start) state_d = ACCEPT;
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) state_d = MUL;
      end
      MUL:    state_d = RED;
      RED:    state_d = last_q ? OUT : ACCEPT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q    <= '0;
      y_q    <= '0;
      opx_q  <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (h_load) h_q <= h_ord;
          if (start) begin
            y_q   <= '0;
            cnt_q <= '0;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            opx_q  <= y_q ^ x_ord;
            last_q <= in_last;
          end
        end
        MUL: prod_q <= prod_d;
        RED: begin
          y_q   <= gf128_reduce(prod_q);
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data  = REFLECT ? bit_reverse128(y_q) : y_q;
  assign out_count = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule
